// File: rtl/cardinal_nic_pkg.sv
// Shared constants for the cardinal NIC: register-select codes and packet field layout.
// Packet fields use MSB-first numbering (bit 0 = MSB = vector index DATA_WIDTH-1).
// Ports: none (package).
package cardinal_nic_pkg;

  localparam int DATA_WIDTH = 64;
  localparam int ADDR_WIDTH = 2;

  // Processor register select
  localparam logic [ADDR_WIDTH-1:0] NIC_IB  = 2'b00;
  localparam logic [ADDR_WIDTH-1:0] NIC_IBS = 2'b01;
  localparam logic [ADDR_WIDTH-1:0] NIC_OB  = 2'b10;
  localparam logic [ADDR_WIDTH-1:0] NIC_OBS = 2'b11;

  // Packet fields as vector indices (MSB-first bit n maps to index 63-n)
  localparam int PKT_VC       = 63;  // bit 0
  localparam int PKT_DIR_HI   = 62;  // bits 1:2
  localparam int PKT_DIR_LO   = 61;
  localparam int PKT_RSV_HI   = 60;  // bits 3:7
  localparam int PKT_RSV_LO   = 56;
  localparam int PKT_HOP_HI   = 55;  // bits 8:15
  localparam int PKT_HOP_LO   = 48;
  localparam int PKT_PLD_HI   = 31;  // bits 32:63
  localparam int PKT_PLD_LO   = 0;

  // Virtual-channel bit of a packet
  function automatic logic pkt_vc(input logic [DATA_WIDTH-1:0] pkt);
    return pkt[PKT_VC];
  endfunction

endpackage

// File: rtl/cardinal_nic_chan_buf.sv
// nic_chan_buf: one-entry packet register with a full flag.
// Ports: clk/reset, load (captured only while empty), unload (clears full), d in, q/full out.
// Latency: loaded data visible on q the cycle after load; unload of a full entry takes one cycle.
module nic_chan_buf #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  unload,
  input  logic [DATA_WIDTH-1:0] d,
  output logic [DATA_WIDTH-1:0] q,
  output logic                  full
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q    <= '0;
      full <= 1'b0;
    end else if (load && !full) begin
      // A load while full is dropped; contents stay intact.
      q    <= d;
      full <= 1'b1;
    end else if (unload && full) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/cardinal_nic.sv
// cardinal_nic: NIC between a cardinal_cpu PE and its NoC router port.
// Ports: clk/reset; PE side addr/d_in/d_out/nicEn/nicWrEn; router side net_si/net_ri/net_di
// (input channel) and net_so/net_ro/net_do/net_polarity (output channel).
module cardinal_nic
  import cardinal_nic_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] d_in,
  output logic [DATA_WIDTH-1:0] d_out,
  input  logic                  nicEn,
  input  logic                  nicWrEn,
  input  logic                  net_si,
  output logic                  net_ri,
  input  logic [DATA_WIDTH-1:0] net_di,
  output logic                  net_so,
  input  logic                  net_ro,
  output logic [DATA_WIDTH-1:0] net_do,
  input  logic                  net_polarity
);

  logic [DATA_WIDTH-1:0] ib, ob;
  logic                  ib_full, ob_full;
  logic                  pe_rd, pe_wr;

  assign pe_rd = nicEn && !nicWrEn;
  assign pe_wr = nicEn && nicWrEn;

  // Input channel: router may only deliver while the buffer is empty.
  assign net_ri = !ib_full;

  nic_chan_buf #(.DATA_WIDTH(DATA_WIDTH)) u_ib (
    .clk    (clk),
    .reset  (reset),
    .load   (net_si && net_ri),
    .unload (pe_rd && (addr == NIC_IB)),
    .d      (net_di),
    .q      (ib),
    .full   (ib_full)
  );

  // Output channel: send only when the packet's VC matches the router's current polarity.
  assign net_so = ob_full && net_ro && (pkt_vc(ob) == net_polarity);
  assign net_do = net_so ? ob : '0;

  // A write landing in the same cycle as a send sees ob_full=1 and is dropped.
  nic_chan_buf #(.DATA_WIDTH(DATA_WIDTH)) u_ob (
    .clk    (clk),
    .reset  (reset),
    .load   (pe_wr && (addr == NIC_OB)),
    .unload (net_so),
    .d      (d_in),
    .q      (ob),
    .full   (ob_full)
  );

  always_comb begin
    d_out = '0;
    if (pe_rd) begin
      unique case (addr)
        NIC_IB:  d_out = ib;
        NIC_IBS: d_out = {{(DATA_WIDTH-1){1'b0}}, ib_full};
        NIC_OB:  d_out = ob;
        NIC_OBS: d_out = {{(DATA_WIDTH-1){1'b0}}, ob_full};
        default: d_out = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_cardinal_nic.sv
module tb_cardinal_nic;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  addr;
  logic [63:0] d_in, d_out;
  logic        nicEn, nicWrEn;
  logic        net_si, net_ri;
  logic [63:0] net_di;
  logic        net_so, net_ro;
  logic [63:0] net_do;
  logic        net_polarity;

  int errors = 0;
  int checks = 0;

  localparam logic [63:0] PKT_A  = 64'h0000_0000_DEAD_BEEF;
  localparam logic [63:0] PKT_V1 = 64'h8000_0000_0000_00AA;
  localparam logic [63:0] PKT_V0 = 64'h0000_0000_0000_0042;
  localparam logic [63:0] PKT_C  = 64'h0000_0000_0000_0C0C;

  cardinal_nic dut (
    .clk          (clk),
    .reset        (reset),
    .addr         (addr),
    .d_in         (d_in),
    .d_out        (d_out),
    .nicEn        (nicEn),
    .nicWrEn      (nicWrEn),
    .net_si       (net_si),
    .net_ri       (net_ri),
    .net_di       (net_di),
    .net_so       (net_so),
    .net_ro       (net_ro),
    .net_do       (net_do),
    .net_polarity (net_polarity)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Combinational PE read; settles before sampling.
  task automatic rd(input logic [1:0] a, input string tag, input logic [63:0] exp);
    nicEn = 1'b1; nicWrEn = 1'b0; addr = a;
    #1;
    check(tag, d_out, exp);
    nicEn = 1'b0;
    #1;
  endtask

  initial begin
    reset = 1'b1; addr = 2'b00; d_in = '0; nicEn = 1'b0; nicWrEn = 1'b0;
    net_si = 1'b0; net_di = '0; net_ro = 1'b0; net_polarity = 1'b0;
    step(); step();
    reset = 1'b0;
    #1;

    // Reset state
    rd(2'b01, "rst_ib_status", 64'd0);
    rd(2'b11, "rst_ob_status", 64'd0);
    check("rst_net_ri", {63'd0, net_ri}, 64'd1);
    check("rst_net_so", {63'd0, net_so}, 64'd0);
    check("rst_net_do", net_do, 64'd0);
    check("rst_d_out_idle", d_out, 64'd0);

    // Input accept
    net_si = 1'b1; net_di = PKT_A;
    step();
    net_si = 1'b0; net_di = '0;
    #1;
    check("acc_net_ri", {63'd0, net_ri}, 64'd0);
    rd(2'b01, "acc_ib_status", 64'd1);

    // Protocol violation while full: ignored
    net_si = 1'b1; net_di = 64'h1234;
    step();
    net_si = 1'b0;
    #1;
    rd(2'b00, "viol_ib_kept", PKT_A);
    rd(2'b01, "viol_ib_status", 64'd1);

    // Read 00 while router retries: not accepted this cycle
    net_si = 1'b1; net_di = 64'h1234;
    nicEn = 1'b1; nicWrEn = 1'b0; addr = 2'b00;
    #1;
    check("rd_ib_data", d_out, PKT_A);
    check("rd_ib_net_ri", {63'd0, net_ri}, 64'd0);
    step();
    nicEn = 1'b0; net_si = 1'b0;
    #1;
    check("post_rd_net_ri", {63'd0, net_ri}, 64'd1);
    rd(2'b01, "post_rd_status", 64'd0);
    rd(2'b00, "retry_not_taken", PKT_A);

    // Output with VC mismatch waits for polarity flip
    net_ro = 1'b1; net_polarity = 1'b0;
    nicEn = 1'b1; nicWrEn = 1'b1; addr = 2'b10; d_in = PKT_V1;
    step();
    nicEn = 1'b0; nicWrEn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("vc_wait_so", {63'd0, net_so}, 64'd0);
      check("vc_wait_do", net_do, 64'd0);
      step();
    end
    rd(2'b11, "vc_wait_status", 64'd1);
    net_polarity = 1'b1;
    #1;
    check("vc_send_so", {63'd0, net_so}, 64'd1);
    check("vc_send_do", net_do, PKT_V1);
    step();
    check("vc_sent_so", {63'd0, net_so}, 64'd0);
    check("vc_sent_do", net_do, 64'd0);
    rd(2'b11, "vc_sent_status", 64'd0);

    // Write while full is dropped; net_ro releases the original
    net_ro = 1'b0; net_polarity = 1'b0;
    nicEn = 1'b1; nicWrEn = 1'b1; addr = 2'b10; d_in = PKT_V0;
    step();
    check("ro_low_so", {63'd0, net_so}, 64'd0);
    d_in = 64'h5555;
    step();
    nicEn = 1'b0; nicWrEn = 1'b0;
    #1;
    rd(2'b10, "drop_ob_kept", PKT_V0);
    rd(2'b11, "drop_ob_status", 64'd1);
    net_ro = 1'b1;
    #1;
    check("release_so", {63'd0, net_so}, 64'd1);
    check("release_do", net_do, PKT_V0);
    step();
    rd(2'b11, "release_status", 64'd0);

    // Earliest send is the cycle after the write; write colliding with send is dropped
    nicEn = 1'b1; nicWrEn = 1'b1; addr = 2'b10; d_in = PKT_C;
    #1;
    check("same_cycle_no_so", {63'd0, net_so}, 64'd0);
    step();
    d_in = 64'h77;
    #1;
    check("next_cycle_so", {63'd0, net_so}, 64'd1);
    check("next_cycle_do", net_do, PKT_C);
    step();
    nicEn = 1'b0; nicWrEn = 1'b0;
    #1;
    rd(2'b11, "collide_status", 64'd0);
    rd(2'b10, "collide_ob_kept", PKT_C);

    // Reset with both buffers full
    net_ro = 1'b0;
    net_si = 1'b1; net_di = 64'h0ABC;
    nicEn = 1'b1; nicWrEn = 1'b1; addr = 2'b10; d_in = PKT_V0;
    step();
    net_si = 1'b0; nicEn = 1'b0; nicWrEn = 1'b0;
    #1;
    rd(2'b01, "pre_rst_ib_status", 64'd1);
    rd(2'b11, "pre_rst_ob_status", 64'd1);
    reset = 1'b1;
    net_ro = 1'b1;
    step();
    reset = 1'b0;
    #1;
    rd(2'b01, "mid_rst_ib_status", 64'd0);
    rd(2'b11, "mid_rst_ob_status", 64'd0);
    rd(2'b00, "mid_rst_ib_data", 64'd0);
    check("mid_rst_net_ri", {63'd0, net_ri}, 64'd1);
    check("mid_rst_net_so", {63'd0, net_so}, 64'd0);
    check("mid_rst_net_do", net_do, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
